// File: rtl/obstacle_avoid_ctrl_if.sv
// Obstacle-avoidance controller I/O bundle.
// Detector flags and run request in, motor drive and status out.
interface obstacle_avoid_ctrl_if;
  logic       enable;
  logic       front_detected;
  logic       left_detected;
  logic       right_detected;
  logic       back_detected;
  logic       front_right_detected;
  logic       front_left_detected;
  logic       back_right_detected;
  logic       back_left_detected;
  logic [1:0] motor_left;
  logic [1:0] motor_right;
  logic [2:0] state;
  logic       busy;
  logic       maneuver_done;
  logic       fault;

  modport master (
    output enable,
    output front_detected, left_detected,
    output right_detected, back_detected,
    output front_right_detected, front_left_detected,
    output back_right_detected, back_left_detected,
    input  motor_left, motor_right, state,
    input  busy, maneuver_done, fault
  );

  modport slave (
    input  enable,
    input  front_detected, left_detected,
    input  right_detected, back_detected,
    input  front_right_detected, front_left_detected,
    input  back_right_detected, back_left_detected,
    output motor_left, motor_right, state,
    output busy, maneuver_done, fault
  );
endinterface

// File: rtl/obstacle_avoid_ctrl.sv
// Obstacle-avoidance controller: debounced detector vector
// feeding a timed stop/reverse/turn maneuver FSM.
module obstacle_avoid_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned STOP_CYCLES     = 2,
  parameter int unsigned REVERSE_CYCLES  = 8,
  parameter int unsigned TURN_CYCLES     = 16
) (
  input logic             clk,
  input logic             reset,
  obstacle_avoid_ctrl_if.slave io
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CRUISE  = 3'd1,
    S_STOP    = 3'd2,
    S_REVERSE = 3'd3,
    S_TURN_L  = 3'd4,
    S_TURN_R  = 3'd5,
    S_HALT    = 3'd6
  } state_e;

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] STOP_LD = 8'(STOP_CYCLES - 1);
  localparam logic [7:0] REV_LD  = 8'(REVERSE_CYCLES - 1);
  localparam logic [7:0] TURN_LD = 8'(TURN_CYCLES - 1);

  // front | front_right | front_left
  localparam logic [7:0] FRONT_ANY = 8'h31;
  // back | back_right | back_left
  localparam logic [7:0] BACK_ANY  = 8'hC8;

  logic [7:0] raw;
  logic [7:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] stable_q, stable_d;
  logic [7:0] timer_q, timer_d;
  logic       fault_q, fault_d;
  logic       done_q, done_d;
  logic [1:0] ml_q, ml_d;
  logic [1:0] mr_q, mr_d;
  state_e     state_q, state_d;
  logic       multi;
  logic       tmr_zero;

  assign raw = {io.back_left_detected,
                io.back_right_detected,
                io.front_left_detected,
                io.front_right_detected,
                io.back_detected,
                io.right_detected,
                io.left_detected,
                io.front_detected};

  assign multi    = |(stable_q & (stable_q - 8'd1));
  assign tmr_zero = (timer_q == 8'd0);

  // Accept a detector vector only after it holds DEBOUNCE_CYCLES samples.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (raw != cand_q) begin
      cand_d = raw;
      cnt_d  = 8'd0;
    end else if (cnt_q < DB_LAST) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      stable_d = cand_q;
    end
  end

  // Sticky multi-hot flag, cleared whenever the run request drops.
  always_comb begin
    fault_d = io.enable ? (fault_q | multi) : 1'b0;
  end

  // Maneuver sequencing and dwell timer.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    done_d  = 1'b0;
    if (!io.enable) begin
      state_d = S_IDLE;
    end else if ((state_q != S_IDLE) && (fault_q || multi)) begin
      state_d = S_HALT;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_CRUISE;
        S_CRUISE: begin
          if (|(stable_q & FRONT_ANY)) state_d = S_STOP;
          else if (stable_q[1])        state_d = S_TURN_R;
          else if (stable_q[2])        state_d = S_TURN_L;
        end
        S_STOP: begin
          if (tmr_zero) begin
            if (stable_q[5])      state_d = S_TURN_R;
            else if (stable_q[4]) state_d = S_TURN_L;
            else if (stable_q[0]) state_d = S_REVERSE;
            else                  state_d = S_CRUISE;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        S_REVERSE: begin
          if ((|(stable_q & BACK_ANY)) || tmr_zero)
            state_d = S_TURN_L;
          else
            timer_d = timer_q - 8'd1;
        end
        S_TURN_L, S_TURN_R: begin
          if (tmr_zero) begin
            state_d = S_CRUISE;
            done_d  = 1'b1;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
    if (state_d != state_q) begin
      unique case (state_d)
        S_STOP:           timer_d = STOP_LD;
        S_REVERSE:        timer_d = REV_LD;
        S_TURN_L, S_TURN_R: timer_d = TURN_LD;
        default:          timer_d = 8'd0;
      endcase
    end
  end

  // Motor drive follows the next state so it switches with state.
  always_comb begin
    ml_d = 2'b00;
    mr_d = 2'b00;
    unique case (state_d)
      S_CRUISE:  begin ml_d = 2'b01; mr_d = 2'b01; end
      S_REVERSE: begin ml_d = 2'b10; mr_d = 2'b10; end
      S_TURN_L:  begin ml_d = 2'b10; mr_d = 2'b01; end
      S_TURN_R:  begin ml_d = 2'b01; mr_d = 2'b10; end
      default:   begin ml_d = 2'b00; mr_d = 2'b00; end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q   <= 8'd0;
      cnt_q    <= 8'd0;
      stable_q <= 8'd0;
      timer_q  <= 8'd0;
      fault_q  <= 1'b0;
      done_q   <= 1'b0;
      ml_q     <= 2'b00;
      mr_q     <= 2'b00;
      state_q  <= S_IDLE;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      timer_q  <= timer_d;
      fault_q  <= fault_d;
      done_q   <= done_d;
      ml_q     <= ml_d;
      mr_q     <= mr_d;
      state_q  <= state_d;
    end
  end

  assign io.state         = state_q;
  assign io.motor_left    = ml_q;
  assign io.motor_right   = mr_q;
  assign io.maneuver_done = done_q;
  assign io.fault         = fault_q;
  assign io.busy          = (state_q == S_STOP)    ||
                            (state_q == S_REVERSE) ||
                            (state_q == S_TURN_L)  ||
                            (state_q == S_TURN_R);

endmodule

// File: tb/tb_obstacle_avoid_ctrl.sv
// Bench for obstacle_avoid_ctrl: directed vector table, hand
// sequences, and random stimulus against a behavioural model.
module tb_obstacle_avoid_ctrl;

  localparam int D  = 4;
  localparam int NS = 2;
  localparam int NR = 8;
  localparam int NT = 16;

  logic clk = 1'b0;
  logic reset;

  obstacle_avoid_ctrl_if bus ();
  obstacle_avoid_ctrl_if bus2 ();

  obstacle_avoid_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus.slave)
  );

  obstacle_avoid_ctrl #(.STOP_CYCLES(10)) dut2 (
    .clk   (clk),
    .reset (reset),
    .io    (bus2.slave)
  );

  assign bus2.enable               = bus.enable;
  assign bus2.front_detected       = bus.front_detected;
  assign bus2.left_detected        = bus.left_detected;
  assign bus2.right_detected       = bus.right_detected;
  assign bus2.back_detected        = bus.back_detected;
  assign bus2.front_right_detected = bus.front_right_detected;
  assign bus2.front_left_detected  = bus.front_left_detected;
  assign bus2.back_right_detected  = bus.back_right_detected;
  assign bus2.back_left_detected   = bus.back_left_detected;

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int shown  = 0;

  logic       en_r;
  logic [7:0] raw_r;

  // behavioural model state (spec state codes as plain ints)
  int         m_state = 0;
  int         m_age   = 0;
  int         m_hage  = 0;
  logic [7:0] m_held  = 8'd0;
  logic [7:0] m_stable = 8'd0;
  logic       m_fault = 1'b0;
  logic       m_done  = 1'b0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] raw;
    int         n;
    logic [2:0] st;
    logic [1:0] ml;
    logic [1:0] mr;
    logic       busy;
    logic       done;
    logic       fault;
  } vec_t;

  vec_t tv[$];

  function automatic int ones(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic logic [3:0] mot(input int s);
    case (s)
      1:       return 4'b0101;
      3:       return 4'b1010;
      4:       return 4'b1001;
      5:       return 4'b0110;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [9:0] act1();
    return {bus.state, bus.motor_left, bus.motor_right,
            bus.busy, bus.maneuver_done, bus.fault};
  endfunction

  function automatic logic [9:0] act2();
    return {bus2.state, bus2.motor_left, bus2.motor_right,
            bus2.busy, bus2.maneuver_done, bus2.fault};
  endfunction

  task automatic chk(input string nm, input logic [9:0] a,
                     input logic [9:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      if (shown < 30) begin
        shown++;
        $display("FAIL %s @%0t: got st=%0d m=%b/%b busy=%b done=%b flt=%b want st=%0d m=%b/%b busy=%b done=%b flt=%b",
                 nm, $time, a[9:7], a[6:5], a[4:3], a[2], a[1], a[0],
                 e[9:7], e[6:5], e[4:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic drive(input logic r, input logic e,
                       input logic [7:0] v);
    reset = r;
    en_r  = e;
    raw_r = v;
    bus.enable               = e;
    bus.front_detected       = v[0];
    bus.left_detected        = v[1];
    bus.right_detected       = v[2];
    bus.back_detected        = v[3];
    bus.front_right_detected = v[4];
    bus.front_left_detected  = v[5];
    bus.back_right_detected  = v[6];
    bus.back_left_detected   = v[7];
  endtask

  // One clock edge of the specification's behaviour.
  task automatic model_step();
    int   ns;
    logic multi;
    logic nd;
    if (reset) begin
      m_state = 0; m_age = 0; m_hage = 0;
      m_held = 8'd0; m_stable = 8'd0;
      m_fault = 1'b0; m_done = 1'b0;
      return;
    end
    multi = ones(m_stable) > 1;
    ns = m_state;
    nd = 1'b0;
    if (!en_r) ns = 0;
    else if (m_state != 0 && (m_fault || multi)) ns = 6;
    else begin
      case (m_state)
        0: ns = 1;
        1: begin
          if ((m_stable & 8'h31) != 0) ns = 2;
          else if (m_stable[1])        ns = 5;
          else if (m_stable[2])        ns = 4;
        end
        2: if (m_age == NS) begin
          if (m_stable[5])      ns = 5;
          else if (m_stable[4]) ns = 4;
          else if (m_stable[0]) ns = 3;
          else                  ns = 1;
        end
        3: if ((m_stable & 8'hC8) != 0 || m_age == NR) ns = 4;
        4, 5: if (m_age == NT) begin ns = 1; nd = 1'b1; end
        default: ns = m_state;
      endcase
    end
    if (ns != m_state) m_age = 1;
    else m_age++;
    m_state = ns;
    m_done  = nd;
    m_fault = en_r ? (m_fault | multi) : 1'b0;
    if (raw_r != m_held) begin
      m_held = raw_r;
      m_hage = 0;
    end else begin
      m_hage++;
    end
    if (m_hage >= D) m_stable = m_held;
  endtask

  task automatic tick();
    logic [9:0] e;
    logic       b;
    @(posedge clk);
    model_step();
    #1;
    b = (m_state >= 2 && m_state <= 5);
    e = {3'(m_state), mot(m_state), b, m_done, m_fault};
    chk("model", act1(), e);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic add(input logic r, input logic e, input logic [7:0] v,
                     input int n, input logic [2:0] s,
                     input logic [1:0] l, input logic [1:0] rr,
                     input logic b, input logic d, input logic f);
    vec_t x;
    x.rst = r; x.en = e; x.raw = v; x.n = n; x.st = s;
    x.ml = l; x.mr = rr; x.busy = b; x.done = d; x.fault = f;
    tv.push_back(x);
  endtask

  initial begin
    drive(1'b1, 1'b0, 8'h00);

    // full front maneuver, released during REVERSE
    add(1,0,8'h00, 2, 0,2'b00,2'b00,0,0,0);
    add(0,1,8'h00, 1, 1,2'b01,2'b01,0,0,0);
    add(0,1,8'h01, 5, 1,2'b01,2'b01,0,0,0);
    add(0,1,8'h01, 1, 2,2'b00,2'b00,1,0,0);
    add(0,1,8'h01, 1, 2,2'b00,2'b00,1,0,0);
    add(0,1,8'h01, 1, 3,2'b10,2'b10,1,0,0);
    add(0,1,8'h00, 7, 3,2'b10,2'b10,1,0,0);
    add(0,1,8'h00, 1, 4,2'b10,2'b01,1,0,0);
    add(0,1,8'h00,15, 4,2'b10,2'b01,1,0,0);
    add(0,1,8'h00, 1, 1,2'b01,2'b01,0,1,0);
    add(0,1,8'h00, 1, 1,2'b01,2'b01,0,0,0);
    // STOP expiry with front_right
    add(0,1,8'h10, 6, 2,2'b00,2'b00,1,0,0);
    add(0,1,8'h10, 1, 2,2'b00,2'b00,1,0,0);
    add(0,1,8'h10, 1, 4,2'b10,2'b01,1,0,0);
    add(0,1,8'h00,15, 4,2'b10,2'b01,1,0,0);
    add(0,1,8'h00, 1, 1,2'b01,2'b01,0,1,0);
    // STOP expiry with front_left
    add(0,1,8'h20, 6, 2,2'b00,2'b00,1,0,0);
    add(0,1,8'h20, 2, 5,2'b01,2'b10,1,0,0);
    add(0,1,8'h00,15, 5,2'b01,2'b10,1,0,0);
    add(0,1,8'h00, 1, 1,2'b01,2'b01,0,1,0);
    // back in CRUISE is ignored, right turns left
    add(0,1,8'h08,10, 1,2'b01,2'b01,0,0,0);
    add(0,1,8'h04, 5, 1,2'b01,2'b01,0,0,0);
    add(0,1,8'h04, 1, 4,2'b10,2'b01,1,0,0);
    add(0,1,8'h00,16, 1,2'b01,2'b01,0,1,0);
    // reset mid TURN_RIGHT at timer 7
    add(0,1,8'h02, 6, 5,2'b01,2'b10,1,0,0);
    add(0,1,8'h00, 8, 5,2'b01,2'b10,1,0,0);
    add(1,1,8'h00, 1, 0,2'b00,2'b00,0,0,0);
    add(0,1,8'h00, 1, 1,2'b01,2'b01,0,0,0);
    // multi-hot front+left -> HALT, enable low clears
    add(0,1,8'h03, 5, 1,2'b01,2'b01,0,0,0);
    add(0,1,8'h03, 1, 6,2'b00,2'b00,0,0,1);
    add(0,1,8'h03, 3, 6,2'b00,2'b00,0,0,1);
    add(0,0,8'h00, 1, 0,2'b00,2'b00,0,0,0);
    add(0,0,8'h00, 5, 0,2'b00,2'b00,0,0,0);
    add(0,1,8'h00, 1, 1,2'b01,2'b01,0,0,0);
    // REVERSE aborted by back
    add(0,1,8'h01, 6, 2,2'b00,2'b00,1,0,0);
    add(0,1,8'h01, 2, 3,2'b10,2'b10,1,0,0);
    add(0,1,8'h08, 5, 3,2'b10,2'b10,1,0,0);
    add(0,1,8'h08, 1, 4,2'b10,2'b01,1,0,0);
    add(0,1,8'h00,15, 4,2'b10,2'b01,1,0,0);
    add(0,1,8'h00, 1, 1,2'b01,2'b01,0,1,0);

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].en, tv[i].raw);
      ticks(tv[i].n);
      chk($sformatf("vec%0d", i), act1(),
          {tv[i].st, tv[i].ml, tv[i].mr,
           tv[i].busy, tv[i].done, tv[i].fault});
    end

    // left chatter shorter than the debounce window
    begin
      logic [7:0] v = 8'h00;
      for (int i = 0; i < 8; i++) begin
        v ^= 8'h02;
        drive(1'b0, 1'b1, v);
        ticks(3);
        chk("chatter", act1(), {3'd1, 4'b0101, 3'b000});
      end
      ticks(6);
      chk("chatter_end", act1(), {3'd1, 4'b0101, 3'b000});
    end

    // long STOP instance: clear stable at expiry -> CRUISE
    drive(1'b1, 1'b0, 8'h00);
    ticks(2);
    drive(1'b0, 1'b1, 8'h00);
    tick();
    chk("s2_cruise", act2(), {3'd1, 4'b0101, 3'b000});
    drive(1'b0, 1'b1, 8'h01);
    ticks(5);
    chk("s2_pre", act2(), {3'd1, 4'b0101, 3'b000});
    drive(1'b0, 1'b1, 8'h00);
    tick();
    chk("s2_stop", act2(), {3'd2, 4'b0000, 3'b100});
    ticks(9);
    chk("s2_dwell", act2(), {3'd2, 4'b0000, 3'b100});
    tick();
    chk("s2_clear", act2(), {3'd1, 4'b0101, 3'b000});
    tick();
    chk("s2_nodone", act2(), {3'd1, 4'b0101, 3'b000});

    // random stimulus against the model
    drive(1'b1, 1'b0, 8'h00);
    ticks(2);
    for (int seg = 0; seg < 300; seg++) begin
      int         p;
      int         len;
      logic [7:0] v;
      logic       e;
      logic       r;
      p = int'($urandom_range(0, 99));
      if (p < 40)      v = 8'h00;
      else if (p < 85) v = 8'h01 << $urandom_range(0, 7);
      else             v = 8'($urandom);
      e   = ($urandom_range(0, 99) < 94);
      r   = ($urandom_range(0, 99) < 2);
      len = int'($urandom_range(1, 24));
      drive(r, e, v);
      if (r) begin
        tick();
        drive(1'b0, e, v);
      end
      ticks(len);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
